// File: rtl/master_bridge_if.sv
// Bundle of master-side request, APB bus and read-return signals for master_bridge.
// The master modport is the bridge's view; the slave modport is the surrounding system's view.
interface master_bridge_if;
  logic        transfer_Master;
  logic        penable_master;
  logic        pwrite_Master;
  logic [1:0]  Psel;
  logic [31:0] write_paddr_Master;
  logic [31:0] read_paddr_Master;
  logic [31:0] write_data_Master;
  logic        pready_slave;
  logic [31:0] prdata;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] paddr;
  logic        PSEL1;
  logic        PSEL2;
  logic [31:0] apb_read_data;

  modport master (
    input  transfer_Master, penable_master, pwrite_Master, Psel,
           write_paddr_Master, read_paddr_Master, write_data_Master,
           pready_slave, prdata,
    output pwrite, penable, pwdata, paddr, PSEL1, PSEL2, apb_read_data
  );

  modport slave (
    output transfer_Master, penable_master, pwrite_Master, Psel,
           write_paddr_Master, read_paddr_Master, write_data_Master,
           pready_slave, prdata,
    input  pwrite, penable, pwdata, paddr, PSEL1, PSEL2, apb_read_data
  );
endinterface

// File: rtl/master_bridge.sv
// APB master bridge: IDLE/SETUP/ACCESS sequencer toward two slaves with registered outputs.
// Handshake: a request is taken when transfer_Master & penable_master & valid Psel; the slave ends ACCESS with pready_slave.
module master_bridge (
  input  logic          pclk,
  input  logic          Reset,
  master_bridge_if.master bus,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pwrite_q, pwrite_d;
  logic        penable_q, penable_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [1:0]  sel_q, sel_d;
  logic        psel1_q, psel1_d;
  logic        psel2_q, psel2_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start;
  logic        capture;

  assign start = bus.transfer_Master && bus.penable_master &&
                 ((bus.Psel == 2'b01) || (bus.Psel == 2'b10));

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    capture  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          capture = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready_slave) begin
          if (!pwrite_q) rdata_d = bus.prdata;
          if (start) begin
            state_d = SETUP;
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      pwrite_d = bus.pwrite_Master;
      paddr_d  = bus.pwrite_Master ? bus.write_paddr_Master : bus.read_paddr_Master;
      if (bus.pwrite_Master) pwdata_d = bus.write_data_Master;
      sel_d    = bus.Psel;
    end

    // Bus controls are decoded from the next state so every output leaves a flop.
    penable_d = (state_d == ACCESS);
    psel1_d   = (state_d != IDLE) && (sel_d == 2'b01);
    psel2_d   = (state_d != IDLE) && (sel_d == 2'b10);
  end

  always_ff @(posedge pclk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      sel_q     <= 2'b00;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      sel_q     <= sel_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.pwrite        = pwrite_q;
  assign bus.penable       = penable_q;
  assign bus.paddr         = paddr_q;
  assign bus.pwdata        = pwdata_q;
  assign bus.PSEL1         = psel1_q;
  assign bus.PSEL2         = psel2_q;
  assign bus.apb_read_data = rdata_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_master_bridge.sv
// Self-checking bench for master_bridge: directed transfers with a completion scoreboard
// and a monitor that checks each completed APB transfer and its returned read data.
module tb_master_bridge;
  localparam int W = 67;  // {pwrite, paddr, pwdata, PSEL2, PSEL1}

  logic       pclk;
  logic       Reset;
  logic [1:0] state_dbg;

  master_bridge_if bus ();

  master_bridge dut (
    .pclk      (pclk),
    .Reset     (Reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic [W-1:0]  exp_q[$];
  logic [31:0]   rd_exp_q[$];
  logic [31:0]   last_wdata;
  int            n_chk;
  int            n_fail;

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.transfer_Master    = 1'b0;
    bus.penable_master     = 1'b0;
    bus.pwrite_Master      = 1'b0;
    bus.Psel               = 2'b00;
    bus.write_paddr_Master = 32'h0;
    bus.read_paddr_Master  = 32'h0;
    bus.write_data_Master  = 32'h0;
    bus.pready_slave       = 1'b0;
    bus.prdata             = 32'h0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_state"}, W'(state_dbg), W'(2'd0));
    chk({name, "_bus"}, W'({bus.PSEL1, bus.PSEL2, bus.penable}), W'(3'b000));
  endtask

  // Driver: one complete transfer; inputs are scrambled after capture to show they are ignored.
  task automatic xfer(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] rdat, input int waits);
    bus.transfer_Master    = 1'b1;
    bus.penable_master     = 1'b1;
    bus.pwrite_Master      = wr;
    bus.Psel               = sel;
    bus.write_paddr_Master = wr ? addr : 32'hDEAD_0000;
    bus.read_paddr_Master  = wr ? 32'hBEEF_0000 : addr;
    bus.write_data_Master  = data;
    bus.prdata             = rdat;
    bus.pready_slave       = 1'b0;
    if (wr) last_wdata = data;
    else rd_exp_q.push_back(rdat);
    exp_q.push_back({wr, addr, last_wdata, sel});
    @(posedge pclk); #2;
    bus.transfer_Master    = 1'b0;
    bus.penable_master     = 1'b0;
    bus.pwrite_Master      = ~wr;
    bus.write_paddr_Master = $urandom;
    bus.read_paddr_Master  = $urandom;
    bus.write_data_Master  = $urandom;
    bus.Psel               = 2'($urandom_range(0, 3));
    @(negedge pclk);
    chk("setup_state", W'(state_dbg), W'(2'd1));
    chk("setup_ctl", W'({bus.PSEL2, bus.PSEL1, bus.penable}), W'({sel, 1'b0}));
    chk("setup_addr", W'(bus.paddr), W'(addr));
    @(posedge pclk); #2;
    for (int i = 0; i < waits; i++) begin
      @(negedge pclk);
      chk("wait_ctl", W'({bus.PSEL2, bus.PSEL1, bus.penable, bus.pwrite}), W'({sel, 1'b1, wr}));
      chk("wait_addr", W'(bus.paddr), W'(addr));
      @(posedge pclk); #2;
    end
    bus.pready_slave = 1'b1;
    @(negedge pclk);
    chk("access_ctl", W'({bus.PSEL2, bus.PSEL1, bus.penable}), W'({sel, 1'b1}));
    @(posedge pclk); #2;
    bus.pready_slave = 1'b0;
    @(negedge pclk);
    chk_idle("after_xfer");
  endtask

  // Monitor: every completed ACCESS is compared against the scoreboard head.
  initial begin
    logic [W-1:0] e;
    logic [31:0]  r;
    forever begin
      @(negedge pclk);
      if (Reset) chk("psel_excl", W'(bus.PSEL1 & bus.PSEL2), W'(1'b0));
      if (Reset && bus.penable && bus.pready_slave) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", W'(1'b1), W'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("xfer", {bus.pwrite, bus.paddr, bus.pwdata, bus.PSEL2, bus.PSEL1}, e);
          if (!e[W-1]) begin
            r = (rd_exp_q.size() != 0) ? rd_exp_q.pop_front() : 32'hxxxx_xxxx;
            @(posedge pclk); #1;
            chk("read_data", W'(bus.apb_read_data), W'(r));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    last_wdata = 32'h0;
    Reset = 1'b0;
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.transfer_Master    = 1'($urandom);
      bus.penable_master     = 1'($urandom);
      bus.pwrite_Master      = 1'($urandom);
      bus.Psel               = 2'($urandom_range(0, 3));
      bus.write_paddr_Master = $urandom;
      bus.read_paddr_Master  = $urandom;
      bus.write_data_Master  = $urandom;
      bus.pready_slave       = 1'($urandom);
      bus.prdata             = $urandom;
      @(posedge pclk); #2;
    end
    @(negedge pclk);
    chk("reset_ctl", W'({state_dbg, bus.pwrite, bus.penable, bus.PSEL1, bus.PSEL2}), W'(6'h0));
    chk("reset_data", W'({bus.paddr, bus.pwdata}), W'(64'h0));
    chk("reset_rdata", W'(bus.apb_read_data), W'(32'h0));
    idle_inputs();
    @(posedge pclk); #2;
    Reset = 1'b1;
    @(posedge pclk); #2;

    xfer(1'b1, 2'b01, 32'h0000_1234, 32'h0123_4567, 32'h0, 0);
    xfer(1'b0, 2'b01, 32'h0000_5678, 32'h0, 32'h89AB_CDEF, 2);
    xfer(1'b1, 2'b10, 32'h0000_00A0, 32'hCAFE_F00D, 32'h0, 1);
    chk("rdata_hold", W'(bus.apb_read_data), W'(32'h89AB_CDEF));

    // Invalid or disabled requests never leave IDLE
    begin
      logic [3:0] bad [3];
      bad[0] = 4'b1111;  // {transfer, penable_master, Psel}
      bad[1] = 4'b1100;
      bad[2] = 4'b1001;
      for (int i = 0; i < 3; i++) begin
        bus.transfer_Master = bad[i][3];
        bus.penable_master  = bad[i][2];
        bus.Psel            = bad[i][1:0];
        bus.pwrite_Master   = 1'b1;
        bus.write_paddr_Master = 32'h0000_0BAD;
        repeat (2) @(posedge pclk);
        #2;
        @(negedge pclk);
        chk_idle("invalid_req");
      end
      idle_inputs();
    end

    // Back-to-back writes with transfer_Master held high
    @(posedge pclk); #2;
    bus.transfer_Master    = 1'b1;
    bus.penable_master     = 1'b1;
    bus.pwrite_Master      = 1'b1;
    bus.Psel               = 2'b01;
    bus.write_paddr_Master = 32'h0000_0010;
    bus.write_data_Master  = 32'h1111_0010;
    exp_q.push_back({1'b1, 32'h0000_0010, 32'h1111_0010, 2'b01});
    exp_q.push_back({1'b1, 32'h0000_0014, 32'h2222_0014, 2'b01});
    last_wdata = 32'h2222_0014;
    @(posedge pclk); #2;
    @(negedge pclk);
    chk("b2b_setup1", W'({state_dbg, bus.penable, bus.paddr}), W'({2'd1, 1'b0, 32'h0000_0010}));
    @(posedge pclk); #2;
    bus.write_paddr_Master = 32'h0000_0014;
    bus.write_data_Master  = 32'h2222_0014;
    bus.pready_slave       = 1'b1;
    @(negedge pclk);
    chk("b2b_access1", W'({bus.penable, bus.paddr}), W'({1'b1, 32'h0000_0010}));
    @(posedge pclk); #2;
    bus.transfer_Master = 1'b0;
    bus.pready_slave    = 1'b0;
    @(negedge pclk);
    chk("b2b_setup2", W'({state_dbg, bus.penable, bus.PSEL1, bus.paddr}),
        W'({2'd1, 1'b0, 1'b1, 32'h0000_0014}));
    @(posedge pclk); #2;
    bus.pready_slave = 1'b1;
    @(negedge pclk);
    chk("b2b_access2", W'({bus.penable, bus.paddr}), W'({1'b1, 32'h0000_0014}));
    @(posedge pclk); #2;
    idle_inputs();
    @(negedge pclk);
    chk_idle("b2b_end");

    // Asynchronous reset in the middle of ACCESS
    @(posedge pclk); #2;
    bus.transfer_Master    = 1'b1;
    bus.penable_master     = 1'b1;
    bus.pwrite_Master      = 1'b1;
    bus.Psel               = 2'b01;
    bus.write_paddr_Master = 32'h0000_0300;
    bus.write_data_Master  = 32'h3333_3333;
    @(posedge pclk); #2;
    bus.transfer_Master = 1'b0;
    @(posedge pclk); #2;
    @(negedge pclk);
    chk("pre_reset_access", W'({bus.PSEL1, bus.penable}), W'(2'b11));
    #1 Reset = 1'b0;
    #1;
    chk("async_reset", W'({state_dbg, bus.PSEL1, bus.penable, bus.paddr}), W'(36'h0));
    idle_inputs();
    @(posedge pclk); #2;
    Reset = 1'b1;
    last_wdata = 32'h0;
    repeat (2) @(posedge pclk);
    #2;
    @(negedge pclk);
    chk_idle("post_reset");

    repeat (3) @(posedge pclk);
    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
